// File: rtl/dm_cache_responder.sv
// ============================================================================
// dm_cache_responder : direct-mapped read-allocate / write-through cache
// Revision 1.0
// ============================================================================
`default_nettype none

module dm_cache_responder #(
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_BITS  = 8,
    parameter int OFFSET_BITS = 2,
    parameter int HIT_WIDTH   = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cache_read,
    input  logic                  cache_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  cache_ready,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic [HIT_WIDTH-1:0]  hit_count,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_ready
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] r_data_mem [LINES*WORDS];

    logic [TAG_BITS-1:0]    r_tag;
    logic [INDEX_BITS-1:0]  r_index;
    logic [OFFSET_BITS-1:0] r_offset;
    logic [OFFSET_BITS-1:0] r_cnt;

    logic [TAG_BITS-1:0]    w_tag;
    logic [INDEX_BITS-1:0]  w_index;
    logic [OFFSET_BITS-1:0] w_offset;
    logic                   w_hit;
    logic                   w_last;

    assign w_tag    = address[ADDR_WIDTH-1 -: TAG_BITS];
    assign w_index  = address[OFFSET_BITS +: INDEX_BITS];
    assign w_offset = address[OFFSET_BITS-1:0];
    assign w_hit    = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);
    assign w_last   = (r_cnt == {OFFSET_BITS{1'b1}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cache_write) begin
                    w_state_next = S_WRITE;
                end else if (cache_read) begin
                    w_state_next = w_hit ? S_ACK : S_FILL;
                end
            end
            S_FILL:  if (mem_ready && w_last) w_state_next = S_ACK;
            S_WRITE: if (mem_ready) w_state_next = S_ACK;
            S_ACK:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Registered outputs and request latches; valid bits live here so reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_ready    <= 1'b0;
            read_data      <= '0;
            hit_count      <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            r_valid        <= '0;
            r_tag          <= '0;
            r_index        <= '0;
            r_offset       <= '0;
            r_cnt          <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cache_write) begin
                        mem_write      <= 1'b1;
                        mem_address    <= address;
                        mem_write_data <= write_data;
                    end else if (cache_read) begin
                        if (w_hit) begin
                            read_data   <= r_data_mem[{w_index, w_offset}];
                            cache_ready <= 1'b1;
                            if (hit_count != {HIT_WIDTH{1'b1}}) begin
                                hit_count <= hit_count + HIT_WIDTH'(1);
                            end
                        end else begin
                            // Line is invalid while it is being refilled.
                            r_valid[w_index] <= 1'b0;
                            mem_read         <= 1'b1;
                            mem_address      <= {w_tag, w_index, {OFFSET_BITS{1'b0}}};
                            r_tag            <= w_tag;
                            r_index          <= w_index;
                            r_offset         <= w_offset;
                            r_cnt            <= '0;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ready) begin
                        if (r_cnt == r_offset) begin
                            read_data <= mem_read_data;
                        end
                        r_cnt       <= r_cnt + OFFSET_BITS'(1);
                        mem_address <= mem_address + ADDR_WIDTH'(1);
                        if (w_last) begin
                            r_valid[r_index] <= 1'b1;
                            mem_read         <= 1'b0;
                            cache_ready      <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        mem_write   <= 1'b0;
                        cache_ready <= 1'b1;
                    end
                end
                S_ACK: begin
                    cache_ready <= 1'b0;
                end
                default: begin
                    cache_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && cache_write && w_hit) begin
            r_data_mem[{w_index, w_offset}] <= write_data;
        end
        if (r_state == S_FILL && mem_ready) begin
            r_data_mem[{r_index, r_cnt}] <= mem_read_data;
            if (w_last) begin
                r_tag_mem[r_index] <= r_tag;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_cache_responder.sv
// Testbench for dm_cache_responder: memory responder, cache-level model, directed tests.
`default_nettype none

module tb_dm_cache_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cache_read = 1'b0;
    logic        cache_write = 1'b0;
    logic [14:0] address = '0;
    logic [31:0] write_data = '0;
    logic        cache_ready;
    logic [31:0] read_data;
    logic [13:0] hit_count;
    logic        mem_read;
    logic        mem_write;
    logic [14:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = '0;
    logic        mem_ready = 1'b0;

    dm_cache_responder dut (
        .clk            (clk),
        .rst            (rst),
        .cache_read     (cache_read),
        .cache_write    (cache_write),
        .address        (address),
        .write_data     (write_data),
        .cache_ready    (cache_ready),
        .read_data      (read_data),
        .hit_count      (hit_count),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    // Main memory and its word-serial responder, with optional wait states.
    logic [31:0] mem [0:32767];
    int          gap = 0;
    logic [14:0] rd_log [$];
    logic [46:0] wr_log [$];

    initial begin
        int wcnt;
        wcnt = 0;
        for (int i = 0; i < 32768; i++) mem[i] = 32'(i) * 32'h9E3779B1 + 32'h13579BDF;
        forever begin
            @(negedge clk);
            if (rst && (mem_read || mem_write)) begin
                if (wcnt >= gap) begin
                    mem_ready = 1'b1;
                    wcnt = 0;
                    if (mem_read) begin
                        mem_read_data = mem[mem_address];
                        rd_log.push_back(mem_address);
                    end else begin
                        mem[mem_address] = mem_write_data;
                        wr_log.push_back({mem_address, mem_write_data});
                    end
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Cache model: which block each line holds, plus the running hit total.
    logic       mv [256];
    logic [4:0] mt [256];
    int         mhits = 0;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int          hits;
        int          lat;
        int          issue;
    } exp_t;
    exp_t exp_q [$];

    logic [31:0] last_rdata = '0;
    int          last_lat = 0;

    initial begin : cmp
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 1'b0;
                continue;
            end
            chk("mem_rw_exclusive", 64'(mem_read && mem_write), 64'd0);
            chk("ready_width", 64'(prev && cache_ready), 64'd0);
            if (cache_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_rd) chk("read_data", 64'(read_data), 64'(e.data));
                    chk("hit_count", 64'(hit_count), 64'(e.hits));
                    chk("latency", 64'(cyc - e.issue), 64'(e.lat));
                    last_rdata = read_data;
                    last_lat   = cyc - e.issue;
                end
            end
            prev = cache_ready;
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mv[i] = 1'b0;
        mhits = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        cache_read = 1'b0;
        cache_write = 1'b0;
        #1;
        chk("rst_ready", 64'(cache_ready), 64'd0);
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_hit_count", 64'(hit_count), 64'd0);
        chk("rst_read_data", 64'(read_data), 64'd0);
        chk("rst_mem_address", 64'(mem_address), 64'd0);
        chk("rst_mem_wdata", 64'(mem_write_data), 64'd0);
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_req(input bit wr, input logic [14:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        int   idx;
        logic [4:0] tg;
        @(negedge clk);
        idx     = int'(a[9:2]);
        tg      = a[14:10];
        e.issue = cyc;
        e.is_rd = !wr;
        e.data  = '0;
        if (wr) begin
            e.lat = 2 + gap;
        end else begin
            if (mv[idx] && mt[idx] == tg) begin
                if (mhits < 16383) mhits++;
                e.lat = 1;
            end else begin
                mv[idx] = 1'b1;
                mt[idx] = tg;
                e.lat   = 4 * gap + 5;
            end
            e.data = mem[a];
        end
        e.hits = mhits;
        exp_q.push_back(e);
        address     = a;
        write_data  = d;
        cache_write = wr;
        cache_read  = !wr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cache_ready && n < 300);
        if (!cache_ready) begin
            chk("req_timeout", 64'd1, 64'd0);
            exp_q.delete();
        end
        cache_read  = 1'b0;
        cache_write = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int n;
        model_clear();

        // Cold block: one fill, then three hits.
        do_reset();
        b = rd_log.size();
        for (int k = 0; k < 4; k++) do_req(1'b0, 15'(1024 + k), 32'd0);
        chk("t1_words", 64'(rd_log.size() - b), 64'd4);
        for (int k = 0; k < 4; k++) chk("t1_fill_addr", 64'(rd_log[b + k]), 64'(1024 + k));
        chk("t1_hits", 64'(hit_count), 64'd3);
        chk("t1_last_data", 64'(last_rdata), 64'(mem[1027]));

        // Sequential sweep: one miss per four reads.
        do_reset();
        b = rd_log.size();
        for (int k = 0; k < 8192; k++) do_req(1'b0, 15'(1024 + k), 32'd0);
        chk("sweep_hits", 64'(hit_count), 64'd6144);
        chk("sweep_words", 64'(rd_log.size() - b), 64'd8192);

        // Conflict eviction on index 0.
        do_reset();
        b = rd_log.size();
        do_req(1'b0, 15'd1024, 32'd0);
        do_req(1'b0, 15'd2048, 32'd0);
        do_req(1'b0, 15'd1024, 32'd0);
        chk("conflict_hits", 64'(hit_count), 64'd0);
        chk("conflict_words", 64'(rd_log.size() - b), 64'd12);
        chk("conflict_addr", 64'(rd_log[b + 4]), 64'd2048);

        // Slow memory: five idle cycles before every word.
        gap = 5;
        do_req(1'b0, 15'd1029, 32'd0);
        chk("stall_latency", 64'(last_lat), 64'd25);
        chk("stall_data", 64'(last_rdata), 64'(mem[1029]));
        gap = 0;

        // Write-through to a cached word, then to an uncached one.
        b = wr_log.size();
        do_req(1'b1, 15'd1025, 32'hDEADBEEF);
        chk("wr_count", 64'(wr_log.size() - b), 64'd1);
        chk("wr_record", 64'(wr_log[b]), 64'({15'd1025, 32'hDEADBEEF}));
        b = rd_log.size();
        do_req(1'b0, 15'd1025, 32'd0);
        chk("wr_hit_nofetch", 64'(rd_log.size() - b), 64'd0);
        chk("wr_hit_data", 64'(last_rdata), 64'hDEADBEEF);
        chk("wr_hit_count", 64'(hit_count), 64'd1);
        do_req(1'b1, 15'd3000, 32'h12345678);
        chk("wr_noalloc", 64'(rd_log.size() - b), 64'd0);
        do_req(1'b0, 15'd3000, 32'd0);
        chk("wr_miss_words", 64'(rd_log.size() - b), 64'd4);
        chk("wr_miss_data", 64'(last_rdata), 64'h12345678);
        chk("wr_miss_hits", 64'(hit_count), 64'd1);

        // Reset after two fill words aborts the fill.
        @(negedge clk);
        b = rd_log.size();
        address = 15'd5000;
        cache_read = 1'b1;
        n = 0;
        while (rd_log.size() < b + 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("abort_reach", 64'(rd_log.size() - b), 64'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_mem_read", 64'(mem_read), 64'd0);
        chk("abort_ready", 64'(cache_ready), 64'd0);
        chk("abort_hits", 64'(hit_count), 64'd0);
        cache_read = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        b = rd_log.size();
        do_req(1'b0, 15'd5000, 32'd0);
        chk("abort_refill_words", 64'(rd_log.size() - b), 64'd4);
        for (int k = 0; k < 4; k++) chk("abort_refill_addr", 64'(rd_log[b + k]), 64'(5000 + k));
        chk("abort_refill_lat", 64'(last_lat), 64'd5);
        chk("abort_refill_hits", 64'(hit_count), 64'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dm_cache_responder.md
Name: dm_cache_responder

Overview:
- Direct-mapped, read-allocate, write-through/no-allocate cache. It answers the cache-side handshake (cache_read / cache_write / address / cache_ready) driven by the access-sequencing controller.
- Reports a running read-hit count, used upstream to compute hit rate.
- Misses are filled from main memory over a word-serial request/ready interface.
- Sits between the access controller and the main-memory model.

Parameters:
- ADDR_WIDTH, 15, word address width (32K-word main memory).
- DATA_WIDTH, 32, word width.
- INDEX_BITS, 8, line index bits (256 lines).
- OFFSET_BITS, 2, word-in-block bits (4 words/block); tag = ADDR_WIDTH-INDEX_BITS-OFFSET_BITS = 5 bits.
- HIT_WIDTH, 14, hit counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cache_read  in  1  read request level, held until cache_ready seen.
- cache_write  in  1  write request level, held until cache_ready seen.
- address  in  ADDR_WIDTH  word address {tag, index, offset}.
- write_data  in  DATA_WIDTH  data for writes.
- cache_ready  out  1  one-cycle completion pulse.
- read_data  out  DATA_WIDTH  valid while cache_ready=1 for reads.
- hit_count  out  HIT_WIDTH  read hits since reset, saturating.
- mem_read  out  1  memory read request level.
- mem_write  out  1  memory write request level.
- mem_address  out  ADDR_WIDTH  memory word address.
- mem_write_data  out  DATA_WIDTH  memory write data.
- mem_read_data  in  DATA_WIDTH  memory data, valid with mem_ready.
- mem_ready  in  1  memory completes current word at this edge.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; all valid bits cleared.
  - cache_ready, mem_read, mem_write = 0; hit_count = 0; read_data = 0; mem_address = 0; mem_write_data = 0.
  - Tag/data arrays need no reset.
  - Reset mid-fill or mid-write aborts immediately: the partially filled line stays invalid and the memory request drops.
- All outputs are registered.
- States: IDLE, FILL, WRITE, ACK.
- Hit = valid[index] && tag_array[index]==address tag.
- IDLE:
  - cache_write=1 has priority over cache_read. If both are high, the write is served and the read stays pending.
  - Read hit: read_data<=data[index][offset]; cache_ready<=1; hit_count+=1 unless all-ones; go ACK. Latency: request seen at edge e, ready high in the cycle after e.
  - Read miss: mem_read<=1; mem_address<={tag,index,0}; word counter<=0; go FILL. hit_count unchanged.
  - Write: if hit, update data[index][offset]. Drive mem_write<=1, mem_address<=address, mem_write_data<=write_data; go WRITE. No allocate on miss.
- FILL:
  - On each edge with mem_ready=1: store mem_read_data into data[index][counter]. If counter==requested offset, capture the word into read_data. Increment counter and mem_address.
  - mem_ready=0 stalls indefinitely with no state change.
  - On the last word (counter==3): write tag, set valid, mem_read<=0, cache_ready<=1, go ACK.
  - A miss costs 4 memory words and is never counted as a hit.
- WRITE: on mem_ready=1: mem_write<=0, cache_ready<=1, go ACK.
- ACK:
  - cache_ready<=0; go IDLE; inputs ignored for this cycle.
  - This dead cycle lets the controller advance address before the next lookup. Best-case throughput is 1 hit per 2 cycles.
- cache_ready is high for exactly one cycle per request.
- mem_read and mem_write are never high together.
- hit_count saturates at 16383; it does not wrap.
- Address and write_data are sampled only in IDLE. Changes during FILL/WRITE are ignored; the line index and offset are latched at request.
- Requests are not abortable. Deasserting cache_read mid-fill still completes the fill and pulses cache_ready.

Test Plan:
- Reset, then read 1024..1027 (tag 1, index 0) -> first access fills 4 words (mem_address 1024..1027); next three are hits; hit_count=3; read_data equals the memory contents each time.
- Controller sweep of 8192 sequential reads from 1024, mem_ready always 1 -> 2048 misses, hit_count=6144 (75%); no cache_ready pulse wider than 1 cycle.
- Read 1024, then 2048 (tag 2, index 0), then 1024 -> three misses (conflict eviction); hit_count=0; 12 memory words fetched.
- Miss with mem_ready low 5 cycles between each word -> FILL holds; cache_ready arrives 1 cycle after the 4th mem_ready; read_data is the requested-offset word.
- Write 0xDEADBEEF to cached 1025, then read 1025 -> mem_write pulse to 1025; the read hits and returns 0xDEADBEEF. Write to uncached 3000 -> no fill, and a subsequent read of 3000 misses.
- Assert rst=0 after 2 fill words -> mem_read=0 and cache_ready=0 immediately, hit_count=0. Re-read the same address -> miss with a full 4-word refill.
